// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   loader_state_e : loader FSM states
//   WORD_BYTES     : bytes per instruction word
//   LEN_BYTES      : bytes in the length prefix
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE
    } loader_state_e;

    localparam int WORD_BYTES = 4;
    localparam int LEN_BYTES  = 2;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   rx_byte        : incoming byte
//   accept         : rx_byte is taken this cycle
//   clear          : drop any partial word (start of a new load)
//   asm_word       : assembled word, valid in the cycle word_done is high
//   word_done      : combinational pulse, high when the 4th byte is accepted
module byte_to_word
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] asm_word,
    output logic        word_done
);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            cnt   <= cnt + 2'd1;
            shreg <= {rx_byte, shreg[23:8]};
        end
    end

    // The final byte bypasses the shift register so the complete word is
    // available in the same cycle it arrives; the top registers it.
    assign asm_word  = {rx_byte, shreg};
    assign word_done = accept && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts LEN_LO, LEN_HI (word count N) then 4*N bytes, and writes
// little-endian words to consecutive word-aligned addresses from 0.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start                 : begin a load (ignored while busy)
//   rx_data/valid/ready   : byte stream handshake
//   mem_we/waddr/wdata    : instruction memory write port (registered)
//   busy, done, err       : status (done/err sticky until next start)
//   cpu_hold              : holds the core in reset
//
// state  | meaning
// IDLE   | after reset, no load yet
// LEN_LO | waiting for low length byte
// LEN_HI | waiting for high length byte, length checked here
// DATA   | receiving data bytes; exits once all words are written
// CSUM   | waiting for checksum byte (checksum build only)
// DONE   | load finished (check err)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam int IDX_W = $clog2(DEPTH);

    loader_state_e    state, state_nx;
    logic [7:0]       len_lo;
    logic [15:0]      words_left;
    logic [IDX_W-1:0] index;
    logic             accept;
    logic             start_ok;
    logic [15:0]      len_word;
    logic             len_over;
    logic [31:0]      asm_word;
    logic             word_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept   = rx_valid && rx_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign len_word = {rx_data, len_lo};
    assign len_over = len_word > 16'(DEPTH);

    byte_to_word u_b2w (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_byte   (rx_data),
        .accept    (accept && (state == DATA)),
        .clear     (start_ok),
        .asm_word  (asm_word),
        .word_done (word_done)
    );

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_nx = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = DATA;
            end
            DATA: begin
                // words_left drops as the last byte arrives, so reaching zero
                // here coincides with the final write cycle (or an empty/bad
                // length), and the exit lands one cycle later.
                rx_ready = (words_left != 16'd0) && !mem_we;
                if (words_left == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = err ? DONE : CSUM;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = DONE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            len_lo     <= '0;
            words_left <= '0;
            index      <= '0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state  <= state_nx;
            mem_we <= word_done;
            if (start_ok) begin
                err        <= 1'b0;
                index      <= '0;
                words_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end
            if (accept && (state == LEN_LO)) len_lo <= rx_data;
            if (accept && (state == LEN_HI)) begin
                if (len_over) begin
                    err        <= 1'b1;
                    words_left <= '0;
                end else begin
                    words_left <= len_word;
                end
            end
            if (word_done) begin
                mem_waddr  <= {{(30 - IDX_W){1'b0}}, index, 2'b00};
                mem_wdata  <= asm_word;
                index      <= index + 1'b1;
                words_left <= words_left - 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept && (state == DATA)) csum <= csum ^ rx_data;
            if (accept && (state == CSUM) && (rx_data != csum)) err <= 1'b1;
`endif
        end
    end

    assign done     = (state == DONE);
    assign busy     = (state != IDLE) && (state != DONE);
    assign cpu_hold = !((state == DONE) && !err);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt = 0;
    int          base;
    logic [7:0]  tb_xor;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(256)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    always @(negedge clk) begin
        if (reset_n && mem_we === 1'b1 && wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_waddr;
            wr_data[wr_cnt] = mem_wdata;
            wr_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout("rx_ready_wait");
        else tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            tb_xor = tb_xor ^ b;
            send_byte(b, (i == 0) ? gap : 0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tb_xor = 8'h00;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout("done_wait");
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
        chk({tag, "_waddr"},    mem_waddr,     32'h0);
        chk({tag, "_wdata"},    mem_wdata,     32'h0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        tb_xor = 8'h00;
        // Reset state
        repeat (3) tick();
        check_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Nominal two-word load, rx_valid held high across bubbles
        base = wr_cnt;
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_rx_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h00100013, 0);
        chk("nom_w0_we", 32'(mem_we), 32'd1);
        chk("nom_w0_bubble", 32'(rx_ready), 32'd0);
        chk("nom_w0_addr", mem_waddr, 32'h0);
        chk("nom_w0_data", mem_wdata, 32'h00100013);
        send_word(32'h00200093, 0);
        chk("nom_w1_we", 32'(mem_we), 32'd1);
        chk("nom_w1_addr", mem_waddr, 32'h4);
        chk("nom_w1_data", mem_wdata, 32'h00200093);
        chk("nom_w1_done_early", 32'(done), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tick();
        send_byte(tb_xor, 0);
`else
        tick();
`endif
        rx_valid = 1'b0;
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_busy", 32'(busy), 32'd0);
        chk("nom_err", 32'(err), 32'd0);
        chk("nom_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("nom_writes", 32'(wr_cnt - base), 32'd2);

        // Zero length
        base = wr_cnt;
        do_start();
        chk("zero_hold_during", 32'(cpu_hold), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        chk("zero_done_t1", 32'(done), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tick();
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
`else
        tick();
`endif
        chk("zero_done_t2", 32'(done), 32'd1);
        chk("zero_err", 32'(err), 32'd0);
        chk("zero_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("zero_writes", 32'(wr_cnt - base), 32'd0);

        // Back-pressure: 3 words with random valid gaps, stray start mid-load
        base = wr_cnt;
        do_start();
        send_byte(8'h03, $urandom_range(0, 2));
        send_byte(8'h00, $urandom_range(0, 2));
        send_word(32'h11223344, $urandom_range(0, 2));
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'hA5A55A5A, $urandom_range(1, 3));
        send_word(32'hDEADBEEF, $urandom_range(0, 2));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor, $urandom_range(0, 2));
`endif
        rx_valid = 1'b0;
        wait_done();
        chk("bp_writes", 32'(wr_cnt - base), 32'd3);
        chk("bp_a0", wr_addr[base],     32'h0);
        chk("bp_d0", wr_data[base],     32'h11223344);
        chk("bp_a1", wr_addr[base + 1], 32'h4);
        chk("bp_d1", wr_data[base + 1], 32'hA5A55A5A);
        chk("bp_a2", wr_addr[base + 2], 32'h8);
        chk("bp_d2", wr_data[base + 2], 32'hDEADBEEF);
        chk("bp_err", 32'(err), 32'd0);

        // Length overflow: N = 257
        base = wr_cnt;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        rx_valid = 1'b0;
        wait_done();
        repeat (3) tick();
        chk("ovf_writes", 32'(wr_cnt - base), 32'd0);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_cpu_hold", 32'(cpu_hold), 32'd1);

        // Reset mid-load after 6 data bytes
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h00100013, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rx_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        base = wr_cnt;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor, 0);
`endif
        rx_valid = 1'b0;
        wait_done();
        chk("rl_writes", 32'(wr_cnt - base), 32'd1);
        chk("rl_addr", wr_addr[base], 32'h0);
        chk("rl_data", wr_data[base], 32'hCAFEF00D);
        chk("rl_cpu_hold", 32'(cpu_hold), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum 0x03
        base = wr_cnt;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h00100013, 0);
        send_byte(8'h03, 0);
        rx_valid = 1'b0;
        wait_done();
        chk("cs_ok_err", 32'(err), 32'd0);
        chk("cs_ok_hold", 32'(cpu_hold), 32'd0);
        chk("cs_ok_writes", 32'(wr_cnt - base), 32'd1);
        // Bad checksum 0x04
        base = wr_cnt;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h00100013, 0);
        send_byte(8'h04, 0);
        rx_valid = 1'b0;
        wait_done();
        chk("cs_bad_err", 32'(err), 32'd1);
        chk("cs_bad_hold", 32'(cpu_hold), 32'd1);
        chk("cs_bad_writes", 32'(wr_cnt - base), 32'd1);
        chk("cs_bad_addr", wr_addr[base], 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU's word-addressed instruction memory. It accepts a length-prefixed byte stream (e.g. from a UART receiver) over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction memory's write port at consecutive word-aligned byte addresses. It holds the CPU in reset while loading, then releases it so the core fetches from address 0 with `addr[31:2]` word indexing.

## Interface
- `DEPTH`, 256 — instruction memory size in 32-bit words; maximum loadable word count.
- `clk` input 1 — single clock; all logic on rising edge.
- `reset_n` input 1 — reset, asynchronous and active-low.
- `start` input 1 — single-cycle pulse that begins a load; ignored while `busy`.
- `rx_data` input 8 — incoming stream byte.
- `rx_valid` input 1 — `rx_data` is valid.
- `rx_ready` output 1 — loader can accept a byte; a byte transfers when `rx_valid && rx_ready`.
- `mem_we` output 1 — single-cycle write strobe to instruction memory.
- `mem_waddr` output 32 — byte address of the write, always word-aligned (`[1:0]` = 0).
- `mem_wdata` output 32 — instruction word to write.
- `busy` output 1 — a load is in progress.
- `done` output 1 — sticky; the last load finished. Cleared by the next accepted `start`.
- `err` output 1 — sticky; the last load failed. Cleared by the next accepted `start`.
- `cpu_hold` output 1 — high holds the core in reset; high from reset until the first load finishes, and high during every load.

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then 4·N data bytes. Each word is sent least-significant byte first.
- States and transitions:
  - `IDLE` → `LEN_LO` on `start`.
  - `LEN_LO` → `LEN_HI` on a byte.
  - `LEN_HI` → `DATA` on a byte.
  - `DATA` → `DONE` after 4·N bytes.
  - `DONE` → `LEN_LO` on `start`.
- Length checks, made on acceptance of `LEN_HI`:
  - N = 0: go to `DONE` directly; no writes.
  - N > DEPTH: set `err`, go to `DONE`; no writes.
- Byte assembly: a 2-bit byte counter shifts bytes into a 32-bit assembly register. The 4th byte completes the word.
- Address counter: word index starts at 0 and increments after each write. `mem_waddr = {index, 2'b00}`. Index width is `$clog2(DEPTH)`, zero-extended to 32 bits. The index never wraps, because N ≤ DEPTH is enforced.
- `rx_ready` is high only in `LEN_LO`, `LEN_HI` and `DATA`. It is low in `IDLE`, in `DONE` and during the write cycle.
- `busy` is high in every state except `IDLE` and `DONE`.
- `cpu_hold` deasserts in `DONE` only if `err` = 0. After an error it stays high until a successful load.
- A `start` in the same cycle as the final data byte is ignored.
- Reset mid-load:
  - Everything returns to reset values and any partial word is discarded.
  - Words already written remain in memory, but `done` = 0.

## Timing
- Reset values:
  - `rx_ready` = 0, `mem_we` = 0, `mem_waddr` = 0, `mem_wdata` = 0.
  - `busy` = 0, `done` = 0, `err` = 0, `cpu_hold` = 1.
  - State `IDLE`.
- `start` sampled in cycle t → `busy` = 1 and `rx_ready` = 1 in cycle t+1.
- Write latency: 4th byte of a word accepted in cycle t → `mem_we` = 1 with valid `mem_waddr` and `mem_wdata` in cycle t+1 (registered outputs). `rx_ready` = 0 in cycle t+1, giving one bubble per word.
- After the last word's write cycle t+1:
  - `done` = 1 and `busy` = 0 in cycle t+2.
  - `cpu_hold` = 0 in cycle t+2 (if no error).
- `rx_valid` may stay high across the bubble; the byte is held and accepted when `rx_ready` returns.
- Peak throughput: 4 bytes per 5 cycles.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A `CSUM` state follows `DATA` and accepts one extra byte.
  - That byte must equal the XOR of all 4·N data bytes (length bytes excluded). For N = 0 the expected value is 0x00.
  - On mismatch, `err` = 1 in `DONE`.
  - Words are already written either way; `cpu_hold` follows the rule in Operation.
  - The N > DEPTH abort skips `CSUM`.
- Not defined: there is no `CSUM` state, and `err` arises only from N > DEPTH.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum `loader_state_e` (`IDLE`, `LEN_LO`, `LEN_HI`, `DATA`, `CSUM`, `DONE`);
  - `WORD_BYTES` = 4;
  - `LEN_BYTES` = 2.
- One sub-module, `byte_to_word`:
  - inputs: byte, accept strobe, clear;
  - outputs: assembled 32-bit word and a word-complete pulse;
  - owns the 2-bit byte counter.
- The FSM, address counter and checksum XOR live in the top module.

## Test plan
- Nominal load: start, stream `02 00 13 00 10 00 93 00 20 00` → two writes, (0x0, 0x00100013) then (0x4, 0x00200093); then `done` = 1 and `cpu_hold` = 0.
- Back-pressure: toggle `rx_valid` randomly during a 3-word load → exactly 3 writes with correct data at addresses 0x0, 0x4, 0x8; no byte lost or duplicated.
- Length overflow: with `DEPTH` = 256, send `01 01` (N = 257) → no `mem_we`; `err` = 1, `done` = 1, `cpu_hold` stays 1.
- Zero length: send `00 00` → `done` = 1 two cycles after `LEN_HI`; no writes.
- Reset mid-load: pull `reset_n` low after 6 data bytes → all outputs at reset values immediately (asynchronously); a following full load writes from 0x0.
- With `IMEM_LOADER_CHECKSUM_EN`: a 1-word load `13 00 10 00` plus checksum byte `03` → `err` = 0; the same load with checksum `04` → `err` = 1, and the write to 0x0 still occurs.
